// File: rtl/exhaustive_stim_capture_if.sv
// Bus between the exhaustive stimulus/capture engine and whatever drives it.
//
// Handshake: start is a level, not a valid/ready pair. The engine samples it
// on every rising clock edge and acts on it only while idle or done
// (busy == 0). While busy it is ignored. No acknowledge is returned. The rise
// of done marks a complete sweep. stim, resp_vec and sig are then valid and
// they hold until the next accepted start or a reset.
interface exhaustive_stim_capture_if #(
    parameter int N_WIDTH = 2
);
    logic                    start;
    logic                    resp_in;
    logic [N_WIDTH-1:0]      stim;
    logic                    busy;
    logic                    done;
    logic [2**N_WIDTH-1:0]   resp_vec;
    logic [15:0]             sig;
    logic [1:0]              state_dbg;

    modport master (
        output start, resp_in,
        input  stim, busy, done, resp_vec, sig, state_dbg
    );

    modport slave (
        input  start, resp_in,
        output stim, busy, done, resp_vec, sig, state_dbg
    );
endinterface

// File: rtl/exhaustive_stim_capture.sv
// Exhaustive stimulus sweep with response capture.
// On start, the engine walks stim through 0 .. 2**N_WIDTH-1. It holds each
// vector for SETTLE_CYC settle cycles plus one sample cycle. It captures
// resp_in into resp_vec[stim] on the sample cycle.
// Optional feature macro: STIM_MISR_EN adds a 16-bit MISR signature over the
// sampled responses. Without it, sig is tied to zero.
module exhaustive_stim_capture #(
    parameter int N_WIDTH    = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic                       CK,
    input  logic                       reset,
    exhaustive_stim_capture_if.slave   bus
);
    localparam int                 VEC_W       = 2**N_WIDTH;
    localparam logic [N_WIDTH-1:0] STIM_LAST   = '1;
    localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [N_WIDTH-1:0] stim_q;
    logic [7:0]         count;
    logic [VEC_W-1:0]   resp_q;
    logic               busy_q;
    logic               done_q;
    logic               launch;

    // A sweep can only begin from a resting state; start is ignored mid-sweep.
    assign launch = ((state == IDLE) || (state == DONE)) && bus.start;

    // Sweep sequencer: stim stepping, settle counting and response capture.
    always_ff @(posedge CK) begin
        if (reset) begin
            state  <= IDLE;
            stim_q <= '0;
            count  <= '0;
            resp_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        state  <= SETTLE;
                        stim_q <= '0;
                        count  <= '0;
                        resp_q <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    count <= count + 8'd1;
                    if (count == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    resp_q[stim_q] <= bus.resp_in;
                    if (stim_q == STIM_LAST) begin
                        // The all-ones vector ends the sweep; stim never wraps.
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state  <= SETTLE;
                        stim_q <= stim_q + 1'b1;
                        count  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef STIM_MISR_EN
    logic [15:0] sig_q;

    // CRC-16/CCITT-style MISR folds in one response bit per sample cycle.
    always_ff @(posedge CK) begin
        if (reset) begin
            sig_q <= 16'hFFFF;
        end else if (launch) begin
            sig_q <= 16'hFFFF;
        end else if (state == SAMPLE) begin
            sig_q <= {sig_q[14:0], 1'b0}
                   ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                   ^ {15'b0, bus.resp_in};
        end
    end

    assign bus.sig = sig_q;
`else
    assign bus.sig = 16'h0000;
`endif

    assign bus.stim      = stim_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.resp_vec  = resp_q;
    assign bus.state_dbg = state;

endmodule
